count_pwm_gen: RTL

//  Downstream consumer of the 3-bit free-running up counter. Compares the live count with a

---
 rtl/count_pwm_gen_pkg.sv | 22 ++
 rtl/count_pwm_gen_seq_checker.sv | 36 +++
 rtl/count_pwm_gen.sv | 97 +++++++++
 3 files changed

// File: rtl/count_pwm_gen_pkg.sv
// Shared definitions for the count-driven PWM generator.
// Holds the width-derived constants and the duty clamp used by count_pwm_gen.
package count_pwm_gen_pkg;

  localparam int unsigned W_DEFAULT = 3;

  // Largest count value for a W-bit counter (the value just before a wrap).
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Duty value that keeps the output high for the whole period.
  function automatic int unsigned duty_full(input int unsigned w);
    return 32'd1 << w;
  endfunction

  // Saturate a requested duty to the full-period value.
  function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned full);
    return (duty > full) ? full : duty;
  endfunction

endpackage

// File: rtl/count_pwm_gen_seq_checker.sv
// Sticky detector for illegal count steps. A count may hold or advance by
// one (mod 2**W); anything else sets seq_err until err_clr. A violation on
// the same edge as err_clr keeps the flag set.
module count_seq_checker #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] count,
  input  logic [W-1:0] prev_cnt,
  input  logic         prev_vld,
  input  logic         err_clr,
  output logic         seq_err
);

  logic [W-1:0] cnt_inc;
  logic         bad_step;

  // Classify the current step against the previous sample.
  always_comb begin
    cnt_inc  = prev_cnt + 1'b1;
    bad_step = prev_vld && (count != prev_cnt) && (count != cnt_inc);
  end

  // Sticky error flag: set has priority over clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_err <= 1'b0;
    end else if (bad_step) begin
      seq_err <= 1'b1;
    end else if (err_clr) begin
      seq_err <= 1'b0;
    end
  end

endmodule

// File: rtl/count_pwm_gen.sv
// PWM generator driven by an external free-running up counter.
// A shadow duty register is written at any time; it is promoted to the
// active duty on each counter wrap (7->0 for W=3), so a new duty always
// starts at count 0. pwm_out is registered (1 clk after count), and
// period_tk pulses the cycle after a wrap.
// Optional build macro: COUNT_SEQ_CHECK_EN adds the count sequence checker;
// without it seq_err is tied 0 and err_clr is ignored.
module count_pwm_gen
  import count_pwm_gen_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] count,
  input  logic [W:0]   duty_in,
  input  logic         duty_wr,
  input  logic         err_clr,
  output logic         pwm_out,
  output logic         period_tk,
  output logic         seq_err
);

  localparam logic [W-1:0] CNT_MAX   = W'(cnt_max(W));
  localparam logic [W:0]   DUTY_FULL = (W+1)'(duty_full(W));

  logic [W:0]   duty_sh;
  logic [W:0]   duty_act;
  logic [W:0]   duty_nx;
  logic [W:0]   duty_cl;
  logic [W-1:0] prev_cnt;
  logic         prev_vld;
  logic         wrap;

  // Wrap detect, clamp of the incoming duty and the duty used this edge.
  // On a wrap the shadow value (before any same-edge write) applies at once,
  // so count 0 of the new period already uses it.
  always_comb begin
    duty_cl = (W+1)'(clamp_duty(32'(duty_in), 32'(DUTY_FULL)));
    wrap    = prev_vld && (prev_cnt == CNT_MAX) && (count == '0);
    duty_nx = wrap ? duty_sh : duty_act;
  end

  // Shadow and active duty registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      duty_sh  <= '0;
      duty_act <= '0;
    end else begin
      if (duty_wr) begin
        duty_sh <= duty_cl;
      end
      if (wrap) begin
        duty_act <= duty_sh;
      end
    end
  end

  // Previous-count history used for wrap and sequence detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_cnt <= '0;
      prev_vld <= 1'b0;
    end else begin
      prev_cnt <= count;
      prev_vld <= 1'b1;
    end
  end

  // Registered PWM comparator and period tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_out   <= 1'b0;
      period_tk <= 1'b0;
    end else begin
      pwm_out   <= ({1'b0, count} < duty_nx);
      period_tk <= wrap;
    end
  end

`ifdef COUNT_SEQ_CHECK_EN
  count_seq_checker #(.W(W)) u_seq_checker (
    .clk      (clk),
    .rst      (rst),
    .count    (count),
    .prev_cnt (prev_cnt),
    .prev_vld (prev_vld),
    .err_clr  (err_clr),
    .seq_err  (seq_err)
  );
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign seq_err        = 1'b0;
`endif

endmodule
